// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory interface: load/store controls,
// MMIO register offsets and STATUS bit positions.
package mem_ctrl_pkg;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LB   = 3'd1;
    localparam logic [2:0] RD_LBU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LHU  = 3'd4;
    localparam logic [2:0] RD_LW   = 3'd5;
    localparam logic [2:0] RD_LWU  = 3'd6;
    localparam logic [2:0] RD_LD   = 3'd7;

    localparam logic [2:0] WR_NONE = 3'd0;
    localparam logic [2:0] WR_SB   = 3'd1;
    localparam logic [2:0] WR_SH   = 3'd2;
    localparam logic [2:0] WR_SW   = 3'd3;
    localparam logic [2:0] WR_SD   = 3'd4;

    localparam logic [63:0] MMIO_CYCLE      = 64'h00;
    localparam logic [63:0] MMIO_CONSOLE_TX = 64'h08;
    localparam logic [63:0] MMIO_STATUS     = 64'h10;
    localparam logic [63:0] MMIO_SPAN       = 64'h18;

    localparam int unsigned STATUS_EMPTY   = 0;
    localparam int unsigned STATUS_FULL    = 1;
    localparam int unsigned STATUS_OVF     = 2;
    localparam int unsigned STATUS_CNT_LSB = 4;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W,
        SIZE_D
    } size_e;

    function automatic size_e rd_size(input logic [2:0] ctrl);
        case (ctrl)
            RD_LB, RD_LBU: return SIZE_B;
            RD_LH, RD_LHU: return SIZE_H;
            RD_LW, RD_LWU: return SIZE_W;
            default:       return SIZE_D;
        endcase
    endfunction

    function automatic size_e wr_size(input logic [2:0] ctrl);
        case (ctrl)
            WR_SB:   return SIZE_B;
            WR_SH:   return SIZE_H;
            WR_SW:   return SIZE_W;
            default: return SIZE_D;
        endcase
    endfunction

    function automatic logic is_aligned(input size_e size, input logic [2:0] off);
        case (size)
            SIZE_B:  return 1'b1;
            SIZE_H:  return off[0] == 1'b0;
            SIZE_W:  return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_tx_fifo.sv
// Console TX byte FIFO: push/pop with same-cycle pass-through on full and a sticky
// overflow flag for rejected pushes.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [7:0]       i_data,
    input  logic             i_ready,
    input  logic             i_clr_ovf,
    output logic             o_valid,
    output logic [7:0]       o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       r_buf [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic w_pop;
    logic w_accept;

    assign o_empty    = r_count == '0;
    assign o_full     = r_count == CNT_W'(DEPTH);
    assign o_valid    = !o_empty;
    assign o_data     = o_empty ? 8'h00 : r_buf[r_rptr];
    assign o_count    = r_count;
    assign o_overflow = r_ovf;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_pop    = o_valid && i_ready;
    assign w_accept = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
            if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end else if (i_push && !w_accept) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept && !i_rst) r_buf[r_wptr] <= i_data;
    end

endmodule

// File: rtl/data_mem_resp.sv
// MEM-stage data-memory slave: doubleword RAM with extended loads and byte-enabled
// stores, plus an MMIO window holding a cycle counter and a console TX FIFO.
module data_mem_resp
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] MMIO_BASE   = 64'h0000_0000_1000_0000,
    parameter int unsigned TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_din,
    output logic [63:0] dm_dout,
    output logic        bus_err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W     = $clog2(TX_DEPTH) + 1;
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH_WORDS) << 3;

    logic [63:0] r_mem [DEPTH_WORDS];
    logic [63:0] r_cycle;

    logic             w_rd_en, w_wr_en;
    logic             w_in_ram, w_in_mmio;
    logic             w_rd_ok, w_wr_ok;
    logic [63:0]      w_off;
    logic [2:0]       w_byte;
    logic [IDX_W-1:0] w_idx;
    size_e            w_rd_size, w_wr_size;

    assign w_rd_en   = dm_rd_ctrl != RD_NONE;
    assign w_wr_en   = (dm_wr_ctrl >= WR_SB) && (dm_wr_ctrl <= WR_SD);
    assign w_off     = dm_addr - MMIO_BASE;
    assign w_in_ram  = dm_addr < RAM_BYTES;
    assign w_in_mmio = (dm_addr >= MMIO_BASE) && (w_off < MMIO_SPAN);
    assign w_byte    = dm_addr[2:0];
    assign w_idx     = dm_addr[IDX_W+2:3];
    assign w_rd_size = rd_size(dm_rd_ctrl);
    assign w_wr_size = wr_size(dm_wr_ctrl);

    // MMIO registers only accept full doubleword-aligned addresses.
    assign w_rd_ok = w_rd_en && ((w_in_ram && is_aligned(w_rd_size, w_byte)) ||
                                 (w_in_mmio && w_byte == 3'd0));
    assign w_wr_ok = w_wr_en && ((w_in_ram && is_aligned(w_wr_size, w_byte)) ||
                                 (w_in_mmio && w_byte == 3'd0));
    assign bus_err = !rst && ((w_rd_en && !w_rd_ok) || (w_wr_en && !w_wr_ok));

    logic             w_fifo_valid, w_fifo_full, w_fifo_empty, w_fifo_ovf;
    logic [7:0]       w_fifo_data;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_mmio_we, w_push, w_clr_ovf;

    assign w_mmio_we = !rst && w_wr_ok && w_in_mmio;
    assign w_push    = w_mmio_we && (w_off == MMIO_CONSOLE_TX);
    assign w_clr_ovf = w_mmio_we && (w_off == MMIO_STATUS);

    tx_fifo #(
        .DEPTH(TX_DEPTH),
        .CNT_W(CNT_W)
    ) u_tx_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (w_push),
        .i_data     (dm_din[7:0]),
        .i_ready    (tx_ready),
        .i_clr_ovf  (w_clr_ovf),
        .o_valid    (w_fifo_valid),
        .o_data     (w_fifo_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count),
        .o_overflow (w_fifo_ovf)
    );

    assign tx_valid = w_fifo_valid;
    assign tx_data  = w_fifo_data;

    logic [63:0] w_lane, w_ram_load, w_mmio_load, w_status;

    assign w_lane = r_mem[w_idx] >> {w_byte, 3'b000};

    always_comb begin
        w_ram_load = w_lane;
        case (dm_rd_ctrl)
            RD_LB:   w_ram_load = {{56{w_lane[7]}}, w_lane[7:0]};
            RD_LBU:  w_ram_load = {56'd0, w_lane[7:0]};
            RD_LH:   w_ram_load = {{48{w_lane[15]}}, w_lane[15:0]};
            RD_LHU:  w_ram_load = {48'd0, w_lane[15:0]};
            RD_LW:   w_ram_load = {{32{w_lane[31]}}, w_lane[31:0]};
            RD_LWU:  w_ram_load = {32'd0, w_lane[31:0]};
            default: w_ram_load = w_lane;
        endcase
    end

    always_comb begin
        w_status                          = '0;
        w_status[STATUS_EMPTY]            = w_fifo_empty;
        w_status[STATUS_FULL]             = w_fifo_full;
        w_status[STATUS_OVF]              = w_fifo_ovf;
        w_status[STATUS_CNT_LSB +: 4]     = 4'(w_fifo_count);
    end

    always_comb begin
        w_mmio_load = '0;
        if (w_off == MMIO_CYCLE) begin
            w_mmio_load = r_cycle;
        end else if (w_off == MMIO_STATUS) begin
            w_mmio_load = w_status;
        end
    end

    assign dm_dout = (!rst && w_rd_ok) ? (w_in_ram ? w_ram_load : w_mmio_load) : '0;

    logic [7:0]  w_be_base, w_be;
    logic [63:0] w_wdata;
    logic        w_ram_we;

    always_comb begin
        case (w_wr_size)
            SIZE_B:  w_be_base = 8'h01;
            SIZE_H:  w_be_base = 8'h03;
            SIZE_W:  w_be_base = 8'h0F;
            default: w_be_base = 8'hFF;
        endcase
    end

    assign w_be     = w_be_base << w_byte;
    assign w_wdata  = dm_din << {w_byte, 3'b000};
    assign w_ram_we = !rst && w_wr_ok && w_in_ram;

    // RAM contents survive reset; only the write enable is held off.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 8; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: byte-level memory model, queue FIFO model and
// cycle count derived from elapsed clock edges.
module tb_data_mem_resp;
    import mem_ctrl_pkg::*;

    localparam logic [63:0] BASE      = 64'h0000_0000_1000_0000;
    localparam logic [63:0] RAM_BYTES = 64'd8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  dm_rd_ctrl = '0;
    logic [2:0]  dm_wr_ctrl = '0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_din = '0;
    logic [63:0] dm_dout;
    logic        bus_err;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    always #5 clk = ~clk;

    data_mem_resp #(
        .DEPTH_WORDS(1024),
        .MMIO_BASE  (BASE),
        .TX_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dm_rd_ctrl (dm_rd_ctrl),
        .dm_wr_ctrl (dm_wr_ctrl),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout),
        .bus_err    (bus_err),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    int n_cmp = 0;
    int n_fail = 0;
    longint unsigned edges = 0;
    longint unsigned rel = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_q[$];
    logic [7:0]  exp_tx[$];
    logic [64:0] sb_q[$];
    bit          ref_ovf = 0;

    always @(posedge clk) edges++;

    function automatic void chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    function automatic int acc_size(input logic [2:0] c, input bit is_wr);
        if (is_wr) begin
            case (c)
                3'd1: return 1;
                3'd2: return 2;
                3'd3: return 4;
                default: return 8;
            endcase
        end
        case (c)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5, 3'd6: return 4;
            default: return 8;
        endcase
    endfunction

    // 0 = RAM, 1 = MMIO window, 2 = unmapped
    function automatic int region(input logic [63:0] a);
        if (a < RAM_BYTES) return 0;
        if (a >= BASE && (a - BASE) < 64'd24) return 1;
        return 2;
    endfunction

    function automatic bit access_ok(input logic [63:0] a, input int sz);
        case (region(a))
            0: return (a % 64'(sz)) == 0;
            1: return (a % 64'd8) == 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] rd, input logic [63:0] a, input int sz);
        logic [63:0] v = '0;
        int n;
        if (region(a) == 1) begin
            n = ref_q.size();
            if (a - BASE == 64'd0) return edges - rel;
            if (a - BASE == 64'd16)
                return {56'd0, 4'(n), 1'b0, ref_ovf, n == 8, n == 0};
            return '0;
        end
        for (int i = 0; i < sz; i++) v |= 64'(ref_mem[int'(a[7:0]) + i]) << (8 * i);
        if ((rd == RD_LB || rd == RD_LH || rd == RD_LW) && v[8*sz-1]) v |= ~64'd0 << (8 * sz);
        return v;
    endfunction

    task automatic step(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] a,
                        input logic [63:0] din, input logic rdy,
                        input bit has_c = 0, input logic [64:0] c = '0);
        logic [63:0] exp_d = '0;
        bit rd_en, wr_en, rd_ok, wr_ok, pop, acc;
        int rsz, wsz;
        dm_rd_ctrl = rd;
        dm_wr_ctrl = wr;
        dm_addr    = a;
        dm_din     = din;
        tx_ready   = rdy;
        rd_en = rd != 3'd0;
        wr_en = wr >= 3'd1 && wr <= 3'd4;
        rsz = acc_size(rd, 0);
        wsz = acc_size(wr, 1);
        rd_ok = rd_en && access_ok(a, rsz);
        wr_ok = wr_en && access_ok(a, wsz);
        if (rd_ok) exp_d = model_load(rd, a, rsz);
        if (rd_en || wr_en) sb_q.push_back({(rd_en && !rd_ok) || (wr_en && !wr_ok), exp_d});
        if (has_c) begin
            #3;
            chk("plan_access", {bus_err, dm_dout}, c);
        end
        @(posedge clk);
        pop = ref_q.size() != 0 && rdy;
        acc = ref_q.size() < 8 || pop;
        if (pop) void'(ref_q.pop_front());
        if (wr_ok && region(a) == 0) begin
            for (int i = 0; i < wsz; i++) ref_mem[int'(a[7:0]) + i] = din[8*i +: 8];
        end else if (wr_ok && region(a) == 1) begin
            if (a - BASE == 64'd8) begin
                if (acc) begin
                    ref_q.push_back(din[7:0]);
                    exp_tx.push_back(din[7:0]);
                end else begin
                    ref_ovf = 1;
                end
            end else if (a - BASE == 64'd16) begin
                ref_ovf = 0;
            end
        end
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (tx_valid && n < 20) begin
            step(3'd0, 3'd0, 64'd0, 64'd0, 1'b1);
            n++;
        end
        if (tx_valid) fail("drain_timeout");
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        int kind = $urandom_range(0, 9);
        if (kind <= 5) begin
            a = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a &= ~64'h7;
        end else if (kind <= 7) begin
            a = BASE + 64'(8 * $urandom_range(0, 2));
        end else if (kind == 8) begin
            a = BASE + 64'($urandom_range(0, 23));
        end else begin
            case ($urandom_range(0, 2))
                0: a = RAM_BYTES + 64'($urandom_range(0, 4095));
                1: a = BASE + 64'd24 + 64'($urandom_range(0, 63));
                default: a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            endcase
        end
        return a;
    endfunction

    // Monitor: pops one expectation per presented access; checks the TX channel.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst) begin
            if (dm_rd_ctrl != 3'd0 || (dm_wr_ctrl >= 3'd1 && dm_wr_ctrl <= 3'd4)) begin
                if (sb_q.size() == 0) begin
                    fail("scoreboard_underflow");
                end else begin
                    e = sb_q.pop_front();
                    chk("dm_dout", {1'b0, dm_dout}, {1'b0, e[63:0]});
                    chk("bus_err", 65'(bus_err), 65'(e[64]));
                end
            end else begin
                chk("idle_outputs", {bus_err, dm_dout}, 65'd0);
            end
            chk("tx_valid", 65'(tx_valid), 65'(ref_q.size() != 0));
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail("tx_unexpected_pop");
                else chk("tx_data", 65'(tx_data), 65'(exp_tx.pop_front()));
            end else if (!tx_valid) begin
                chk("tx_data_empty", 65'(tx_data), 65'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        dm_rd_ctrl = RD_LD;
        dm_addr    = BASE;
        #12;
        chk("reset_dout", {1'b0, dm_dout}, 65'd0);
        chk("reset_bus_err", 65'(bus_err), 65'd0);
        chk("reset_tx_valid", 65'(tx_valid), 65'd0);
        chk("reset_tx_data", 65'(tx_data), 65'd0);
        dm_rd_ctrl = RD_NONE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel = edges;

        step(RD_LD, WR_NONE, BASE, 0, 0, 1, 65'd0);
        repeat (9) step(3'd0, 3'd0, 0, 0, 0);
        step(RD_LD, WR_NONE, BASE, 0, 0, 1, 65'd10);

        for (int i = 0; i < 32; i++) step(3'd0, WR_SD, 64'(8 * i), {$urandom, $urandom}, 0);

        step(3'd0, WR_SD, 64'h40, 64'hFFEE_DDCC_BBAA_9988, 0);
        step(RD_LB,  3'd0, 64'h40, 0, 0, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FF88});
        step(RD_LBU, 3'd0, 64'h47, 0, 0, 1, {1'b0, 64'h0000_0000_0000_00FF});
        step(RD_LH,  3'd0, 64'h42, 0, 0, 1, {1'b0, 64'hFFFF_FFFF_FFFF_BBAA});
        step(RD_LWU, 3'd0, 64'h44, 0, 0, 1, {1'b0, 64'h0000_0000_FFEE_DDCC});
        step(RD_LD,  3'd0, 64'h40, 0, 0, 1, {1'b0, 64'hFFEE_DDCC_BBAA_9988});
        step(3'd0, WR_SB, 64'h41, 64'h12, 0);
        step(RD_LD,  3'd0, 64'h40, 0, 0, 1, {1'b0, 64'hFFEE_DDCC_BBAA_1288});
        step(RD_LW,  3'd0, 64'h42, 0, 0, 1, {1'b1, 64'd0});
        step(3'd0, WR_SH, 64'h43, 64'hABCD, 0, 1, {1'b1, 64'd0});
        step(RD_LD,  3'd0, 64'h40, 0, 0, 1, {1'b0, 64'hFFEE_DDCC_BBAA_1288});
        step(RD_LD, WR_SD, 64'h40, 64'h0123_4567_89AB_CDEF, 0, 1,
             {1'b0, 64'hFFEE_DDCC_BBAA_1288});
        step(RD_LD,  3'd0, 64'h40, 0, 0, 1, {1'b0, 64'h0123_4567_89AB_CDEF});

        for (int i = 0; i < 400; i++) begin
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rand_addr(),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        drain();
        step(3'd0, WR_SD, BASE + 64'h10, 0, 0);
        for (int i = 0; i < 9; i++) step(3'd0, WR_SB, BASE + 64'h8, 64'(8'h41 + i), 0);
        step(RD_LD, 3'd0, BASE + 64'h10, 0, 0, 1, {1'b0, 64'h86});
        repeat (8) step(3'd0, 3'd0, 0, 0, 1);
        step(RD_LD, 3'd0, BASE + 64'h10, 0, 1, 1, {1'b0, 64'h05});

        step(3'd0, WR_SD, BASE + 64'h10, 0, 0);
        for (int i = 0; i < 8; i++) step(3'd0, WR_SB, BASE + 64'h8, 64'(8'h60 + i), 0);
        step(3'd0, WR_SD, BASE + 64'h8, 64'h70, 1);
        step(RD_LD, 3'd0, BASE + 64'h10, 0, 0, 1, {1'b0, 64'h82});
        drain();

        for (int i = 0; i < 3; i++) step(3'd0, WR_SB, BASE + 64'h8, 64'(8'h30 + i), 0);
        dm_wr_ctrl = 3'd0;
        dm_rd_ctrl = 3'd0;
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_tx_valid", 65'(tx_valid), 65'd0);
        chk("midreset_tx_data", 65'(tx_data), 65'd0);
        ref_q.delete();
        exp_tx.delete();
        ref_ovf = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel = edges;
        step(RD_LD, 3'd0, BASE, 0, 0, 1, 65'd0);
        step(RD_LD, 3'd0, BASE + 64'h10, 0, 0, 1, {1'b0, 64'h01});
        step(3'd0, 3'd0, 0, 0, 0);

        if (sb_q.size() != 0) fail("scoreboard_leftover");
        if (exp_tx.size() != 0) fail("tx_leftover");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the pipelined RV64 core: the slave end of the MEM-stage `dm_*` interface. It decodes the 3-bit read/write controls, serves little-endian loads with sign/zero extension from a doubleword RAM, and commits byte-enabled stores on the clock edge. A small MMIO window exposes a free-running cycle counter and a console TX FIFO drained through a valid/ready handshake.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 64-bit doublewords; RAM region is `0 .. DEPTH_WORDS*8-1`.
- `MMIO_BASE`, 64'h0000_0000_1000_0000: base of the MMIO window (CYCLE +0x00, CONSOLE_TX +0x08, STATUS +0x10).
- `TX_DEPTH`, 8: console FIFO entries (power of two).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dm_rd_ctrl` in 3: load type; 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD.
- `dm_wr_ctrl` in 3: store type; 0 none, 1 SB, 2 SH, 3 SW, 4 SD, 5–7 treated as none.
- `dm_addr` in 64: byte address.
- `dm_din` in 64: store data, right-aligned.
- `dm_dout` out 64: load data, extended to 64 bits.
- `bus_err` out 1: current access is misaligned or unmapped.
- `tx_valid` out 1: FIFO head is valid.
- `tx_data` out 8: FIFO head byte.
- `tx_ready` in 1: consumer accepts the head.

## Operation
- **RAM loads.** Combinational, zero latency. Index is `dm_addr[..:3]` and byte offset is `dm_addr[2:0]`. The lane selected by the offset is extended: LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD passes through.
- **RAM stores.** Committed at the rising edge using byte enables from type and offset. Unwritten bytes are unchanged.
- **Alignment.** Required alignment is LH/SH 2, LW/SW 4, LD/SD 8.
  - A misaligned access asserts `bus_err`.
  - A misaligned load returns 0.
  - A misaligned store is suppressed.
- **Unmapped addresses.** Any address outside both the RAM and the MMIO window asserts `bus_err`. Reads return 0 and writes are dropped.
- **Simultaneous controls.** If both controls are nonzero, the store executes and `dm_dout` still reflects the pre-edge contents.
- **Idle.** With `dm_rd_ctrl == 0`, `dm_dout` is 0.
- **MMIO.** Accesses must be 8-byte aligned; otherwise `bus_err` is asserted and the access has no effect. MMIO reads return the full 64-bit register regardless of load type.
  - CYCLE (RO): counts +1 every clock from reset and wraps at 2^64. Stores are ignored.
  - CONSOLE_TX (WO): any store pushes `dm_din[7:0]`. Reads return 0.
  - STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:4] count. Any store clears overflow.
- **FIFO.**
  - Push is accepted when count < TX_DEPTH, or when a pop occurs in the same cycle.
  - A rejected push sets overflow.
  - Pop happens when `tx_valid & tx_ready`.
  - Simultaneous push and pop leaves count unchanged. When the FIFO was empty, a same-cycle push cannot be popped.
  - Pointers wrap modulo TX_DEPTH.
  - `tx_data` is 0 when the FIFO is empty.

## Timing
- **Reset values** (asynchronous, while `rst` is high): `dm_dout` = 0, `bus_err` = 0, `tx_valid` = 0, `tx_data` = 0. The cycle counter, FIFO pointers, count and overflow are all cleared.
  - RAM contents are not cleared.
  - Stores and pushes are blocked during reset.
- **Loads:** 0-cycle latency, combinational from `dm_addr`/`dm_rd_ctrl`.
- **Stores:** visible to a load in the cycle after the edge.
- **CYCLE read:** returns the value held before the current edge; the first cycle after reset deasserts reads 0.
- **Push:** `tx_valid` rises the cycle after the pushing edge (1-cycle latency).
- **STATUS:** reflects state before the current edge.
- **Mid-operation reset:** the FIFO is flushed and any in-flight `tx_valid` drops immediately.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - `dm_rd_ctrl` / `dm_wr_ctrl` encodings as localparams (shared with the ID-stage decoder);
  - the MMIO offset constants;
  - STATUS bit positions.
- One sub-module, `tx_fifo`: synchronous FIFO with push/pop/full/empty/count and an overflow flag, instantiated once.
- The RAM array, decode, extension and byte-enable logic stay in `data_mem_resp`.

## Test plan
- **Store then loads.** SD 0xFFEE_DDCC_BBAA_9988 at 0x40. Then:
  - LB @0x40 → 0xFFFF_FFFF_FFFF_FF88
  - LBU @0x47 → 0xFF
  - LH @0x42 → 0xFFFF_FFFF_FFFF_BBAA
  - LWU @0x44 → 0xFFEE_DDCC
  - LD → original value
- **Partial store.** SB 0x12 at 0x41 over the previous data → LD @0x40 = 0xFFEE_DDCC_BBAA_1288.
- **Misaligned.** LW @0x42 → `dm_dout` 0 and `bus_err` 1. SH @0x43 → memory unchanged.
- **Cycle counter.** Deassert `rst`, wait 10 cycles, LD MMIO_BASE → 10. Assert `rst` mid-run → the next read after release is 0.
- **FIFO fill.** With `tx_ready` = 0, push 9 bytes 0x41..0x49 → STATUS = count 8, full, overflow. Raise `tx_ready` → 0x41..0x48 drain in order, one per cycle, then `tx_valid` = 0 and empty = 1.
- **Push on full with pop.** FIFO full with `tx_ready` = 1, push in the same cycle → accepted, count stays 8, overflow not set.
